// File: rtl/serial_pkg.sv
// Shared types and widths for the serial link arbiter slice.
package serial_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_ACC  = 2'd2,
        WAIT_FREE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/serial_rr_pick.sv
// Combinational round-robin pick: first valid requester after last_grant, wrapping.
module serial_rr_pick
    import serial_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     any_valid,
    output logic [$clog2(N_REQ)-1:0] sel
);

    localparam int unsigned SEL_W = $clog2(N_REQ);

    // Scan from the lowest priority down so the highest-priority hit is written last.
    always_comb begin
        int unsigned idx;
        any_valid = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                sel       = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter serialising requester bytes LSB-first into one deserializer input.
// Optional handshake watchdog enabled by defining SERIAL_ARB_TIMEOUT_EN.
module serial_link_arbiter
    import serial_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clock_100KHz,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_grant,
    input  logic                     des_status,
    output logic                     des_data_in,
    output logic                     des_write_in,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     err_timeout
);

    localparam int unsigned SEL_W = $clog2(N_REQ);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [BYTE_W-1:0]    shift_reg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 any_valid;
    logic [SEL_W-1:0]     sel;
    logic [BYTE_W-1:0]    sel_byte;
    logic                 last_bit;

    serial_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .any_valid (any_valid),
        .sel       (sel)
    );

    assign sel_byte = req_data[int'(sel)*BYTE_W +: BYTE_W];
    assign last_bit = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            in_wait;

    assign in_wait = (state == WAIT_ACC) || (state == WAIT_FREE);
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (des_status && any_valid) state_nxt = SHIFT;
            SHIFT:     if (last_bit)                state_nxt = WAIT_ACC;
            WAIT_ACC:  if (!des_status)             state_nxt = WAIT_FREE;
            WAIT_FREE: if (des_status)              state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
`ifdef SERIAL_ARB_TIMEOUT_EN
        wd_expire = 1'b0;
        // Expiry only fires when the handshake made no progress this cycle.
        if (in_wait && (state_nxt == state) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
            state_nxt = IDLE;
            wd_expire = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            req_grant  <= '0;
            last_grant <= SEL_W'(N_REQ - 1);
        end else begin
            state     <= state_nxt;
            req_grant <= '0;
            if (state == IDLE && des_status && any_valid) begin
                shift_reg  <= sel_byte;
                bit_cnt    <= '0;
                req_grant  <= N_REQ'(1) << sel;
                last_grant <= sel;
            end else if (state == SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_ARB_TIMEOUT_EN
    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_expire;
            if (!in_wait || (state_nxt != state)) wd_cnt <= '0;
            else                                  wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    assign des_write_in = (state == SHIFT);
    assign des_data_in  = (state == SHIFT) && shift_reg[bit_cnt];
    assign busy         = (state != IDLE);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("serial_link_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
    end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed self-checking bench for serial_link_arbiter (N_REQ=4, TIMEOUT_CYCLES=16).
module tb_serial_link_arbiter;

    logic        clock_100KHz;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_grant;
    logic        des_status;
    logic        des_data_in;
    logic        des_write_in;
    logic        busy;
    logic [1:0]  last_grant;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_link_arbiter #(
        .N_REQ         (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock_100KHz(clock_100KHz),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_grant   (req_grant),
        .des_status  (des_status),
        .des_data_in (des_data_in),
        .des_write_in(des_write_in),
        .busy        (busy),
        .last_grant  (last_grant),
        .err_timeout (err_timeout)
    );

    initial begin
        clock_100KHz = 1'b0;
        forever #5 clock_100KHz = ~clock_100KHz;
    end

    always @(posedge clock_100KHz) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clock_100KHz);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        des_status = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    // Stimulus helpers only: they gather observations, the test tasks judge them.
    task automatic wait_grant(input int limit, output logic [3:0] g, output int n);
        g = '0;
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (req_grant !== 4'b0000) begin
                g = req_grant;
                break;
            end
        end
    endtask

    task automatic capture_byte(output logic [7:0] b, output int w);
        b = '0;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            b[i] = des_data_in;
            if (des_write_in === 1'b1) w++;
            tick();
        end
    endtask

    task automatic des_ack(input int pre, input int low);
        repeat (pre) tick();
        des_status = 1'b0;
        repeat (low) tick();
        des_status = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        req_valid  = 4'b1111;
        req_data   = 32'hDEADBEEF;
        des_status = 1'b1;
        repeat (3) tick();
        total++;
        if ({req_grant, des_write_in, des_data_in, busy, err_timeout} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got grant=%b wr=%b d=%b busy=%b err=%b want all 0",
                     req_grant, des_write_in, des_data_in, busy, err_timeout);
        end
        total++;
        if (last_grant !== 2'd3) begin
            bad++;
            $display("FAIL reset_last_grant got=%0d want=3", last_grant);
        end
        req_valid = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [3:0] g;
        logic [7:0] b;
        int n, w;
        do_reset();
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        wait_grant(20, g, n);
        req_valid = '0;
        total++;
        if (g !== 4'b0001 || n !== 1) begin
            bad++;
            $display("FAIL single_grant got=%b after %0d want=0001 after 1", g, n);
        end
        total++;
        if (last_grant !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_state got last=%0d busy=%b want last=0 busy=1", last_grant, busy);
        end
        capture_byte(b, w);
        total++;
        if (b !== 8'hA5) begin
            bad++;
            $display("FAIL single_bits got=%h want=a5", b);
        end
        total++;
        if (w !== 8 || des_write_in !== 1'b0) begin
            bad++;
            $display("FAIL single_write_len got=%0d cycles, after=%b want=8 cycles, after=0", w, des_write_in);
        end
        des_ack(0, 1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] g;
        logic [7:0] b;
        logic [7:0] exp_b;
        int n, w, idx;
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx   = k % 4;
            exp_b = 8'h11 * 8'(idx + 1);
            wait_grant(30, g, n);
            total++;
            if (g !== (4'b0001 << idx) || last_grant !== 2'(idx)) begin
                bad++;
                $display("FAIL rr_order[%0d] got grant=%b last=%0d want grant=%b last=%0d",
                         k, g, last_grant, 4'b0001 << idx, idx);
            end
            if (k > 0) begin
                total++;
                if (n !== 1) begin
                    bad++;
                    $display("FAIL rr_bubble[%0d] got %0d cycles want 1", k, n);
                end
            end
            capture_byte(b, w);
            total++;
            if (b !== exp_b || w !== 8) begin
                bad++;
                $display("FAIL rr_byte[%0d] got=%h/%0d want=%h/8", k, b, w, exp_b);
            end
            des_ack(2, 1);
        end
        req_valid = '0;
    endtask

    task automatic test_status_hold;
        logic [3:0] g;
        logic [7:0] b;
        int n, w;
        logic seen;
        do_reset();
        des_status     = 1'b0;
        req_data[23:16] = 8'h5A;
        req_valid      = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_grant !== 4'b0000 || des_write_in !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL hold_no_grant got activity=%b want 0", seen);
        end
        des_status = 1'b1;
        tick();
        total++;
        if (req_grant !== 4'b0100 || des_write_in !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got grant=%b wr=%b want 0100/1", req_grant, des_write_in);
        end
        req_valid = '0;
        capture_byte(b, w);
        total++;
        if (b !== 8'h5A) begin
            bad++;
            $display("FAIL hold_byte got=%h want=5a", b);
        end
        des_ack(0, 1);
    endtask

    task automatic test_reset_mid;
        logic [3:0] g;
        logic [7:0] b;
        int n, w;
        req_data[7:0] = 8'h3C;
        req_valid     = 4'b0001;
        wait_grant(20, g, n);
        req_valid = '0;
        repeat (4) tick();
        total++;
        if (g !== 4'b0001 || des_write_in !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got grant=%b wr=%b want 0001/1", g, des_write_in);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({req_grant, des_write_in, des_data_in, busy} !== 7'h00 || last_grant !== 2'd3) begin
            bad++;
            $display("FAIL mid_async got grant=%b wr=%b d=%b busy=%b last=%0d want 0/0/0/0/3",
                     req_grant, des_write_in, des_data_in, busy, last_grant);
        end
        req_data[23:16] = 8'h96;
        req_valid       = 4'b0100;
        repeat (2) tick();
        reset = 1'b1;
        wait_grant(20, g, n);
        req_valid = '0;
        total++;
        if (g !== 4'b0100 || n !== 1) begin
            bad++;
            $display("FAIL mid_regrant got=%b after %0d want=0100 after 1", g, n);
        end
        capture_byte(b, w);
        total++;
        if (b !== 8'h96 || w !== 8) begin
            bad++;
            $display("FAIL mid_byte got=%h/%0d want=96/8", b, w);
        end
        des_ack(0, 1);
    endtask

    task automatic test_back_to_back;
        logic [3:0] g;
        logic [7:0] b;
        logic [7:0] bytes [3];
        int tg [3];
        int n, w;
        bytes[0] = 8'h12;
        bytes[1] = 8'h34;
        bytes[2] = 8'h56;
        do_reset();
        req_data[15:8] = bytes[0];
        req_valid      = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_grant(30, g, n);
            tg[k] = cyc;
            if (k < 2) req_data[15:8] = bytes[k+1];
            else       req_valid = '0;
            total++;
            if (g !== 4'b0010) begin
                bad++;
                $display("FAIL b2b_grant[%0d] got=%b want=0010", k, g);
            end
            capture_byte(b, w);
            total++;
            if (b !== bytes[k]) begin
                bad++;
                $display("FAIL b2b_byte[%0d] got=%h want=%h", k, b, bytes[k]);
            end
            des_ack(0, 1);
        end
        for (int k = 1; k < 3; k++) begin
            total++;
            if (tg[k] - tg[k-1] !== 11) begin
                bad++;
                $display("FAIL b2b_spacing[%0d] got=%0d want=11", k, tg[k] - tg[k-1]);
            end
        end
    endtask

`ifdef SERIAL_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [3:0] g;
        logic [7:0] b;
        int n, w;
        do_reset();
        req_data[31:24] = 8'hC3;
        req_valid       = 4'b1000;
        wait_grant(20, g, n);
        req_data[31:24] = 8'h3C;
        capture_byte(b, w);
        n = 0;
        do begin
            tick();
            n++;
        end while (err_timeout !== 1'b1 && n < 40);
        total++;
        if (n !== 16 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse got %0d cycles busy=%b want 16 busy=0", n, busy);
        end
        wait_grant(20, g, n);
        req_valid = '0;
        total++;
        if (g !== 4'b1000 || n !== 1 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_next got grant=%b after %0d err=%b want 1000 after 1 err=0", g, n, err_timeout);
        end
        capture_byte(b, w);
        total++;
        if (b !== 8'h3C) begin
            bad++;
            $display("FAIL timeout_byte got=%h want=3c", b);
        end
        des_ack(0, 1);
    endtask
`else
    task automatic test_no_timeout;
        logic [3:0] g;
        logic [7:0] b;
        int n, w;
        logic saw_err, saw_idle;
        do_reset();
        req_data[7:0] = 8'h77;
        req_valid     = 4'b0001;
        wait_grant(20, g, n);
        req_valid = '0;
        capture_byte(b, w);
        saw_err  = 1'b0;
        saw_idle = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (err_timeout !== 1'b0) saw_err = 1'b1;
            if (busy !== 1'b1) saw_idle = 1'b1;
        end
        total++;
        if (saw_err !== 1'b0 || saw_idle !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout got err=%b left_wait=%b want 0/0", saw_err, saw_idle);
        end
        des_ack(0, 1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout_idle got busy=%b want 0", busy);
        end
    endtask
`endif

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        des_status = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_status_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion want finish before limit");
        $fatal(1, "bench time limit reached");
    end

endmodule
